// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory controller definitions.
// Holds the arbiter/sequencer state encoding, requester port ids,
// the default size of the valid byte-address space and the width
// of the wait-state counter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Port 0 is the CPU load/store stage, port 1 the debug/DMA loader.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    localparam int unsigned MEM_BYTES_DEF = 256;
    localparam int unsigned WAIT_W        = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req0, req1  : pending requests
//   ptr         : port that wins when both request
//   gnt_id      : granted port (meaningful when gnt_valid)
//   gnt_valid   : at least one request pending
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t ptr,
    output port_t gnt_id,
    output logic  gnt_valid
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ptr;
        end else if (req1) begin
            gnt_id = PORT1;
        end else begin
            gnt_id = PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter/sequencer: shares one single-port data memory
// between the CPU load/store stage (port 0) and the debug/DMA loader
// (port 1). Round-robin, one transaction in flight, req/ack per port.
// Ports:
//   clk, reset              : clock, async active-high reset
//   req*/we*/addr*/wdata*   : requester side, held until ack
//   ack0, ack1              : one-cycle completion pulse
//   err                     : with ack, misaligned or out-of-range access
//   rdata                   : registered read data, valid with ack
//   mem_address, mem_data_input, mem_MemRead, mem_MemWrite : to memory
//   mem_data_Out            : combinational read data from memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_input,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_data_Out
);

    state_t              state, state_nxt;
    port_t               ptr;
    port_t               arb_id;
    logic                arb_valid;
    port_t               gnt_q;
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WAIT_W-1:0]   wcnt;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                bad_addr;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .ptr       (ptr),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    // Request fields of whichever port the arbiter would grant now.
    always_comb begin
        if (arb_id == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end else begin
            sel_we    = we0;
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end
        bad_addr = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_W'(MEM_BYTES));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; errors skip the memory access entirely.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (arb_valid) state_nxt = bad_addr ? S_RESP : S_ACCESS;
            S_ACCESS: if (wcnt == '0) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Latched transaction, wait counter, read capture and priority pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= PORT0;
            gnt_q   <= PORT0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wcnt    <= '0;
            rdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        gnt_q   <= arb_id;
                        we_q    <= sel_we;
                        err_q   <= bad_addr;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wcnt    <= WAIT_W'(WAIT_STATES);
                        rdata   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else if (!we_q) begin
                        rdata <= mem_data_Out;
                    end
                end
                S_RESP: begin
                    ptr <= (gnt_q == PORT0) ? PORT1 : PORT0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and latched transaction only.
    always_comb begin
        ack0           = (state == S_RESP) && (gnt_q == PORT0);
        ack1           = (state == S_RESP) && (gnt_q == PORT1);
        err            = (state == S_RESP) && err_q;
        mem_MemRead    = (state == S_ACCESS) && !we_q;
        mem_MemWrite   = (state == S_ACCESS) && we_q;
        mem_address    = (state == S_ACCESS) ? addr_q  : '0;
        mem_data_input = (state == S_ACCESS) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: two instances (WAIT_STATES 0 and 2)
// each attached to a behavioural 64-word memory. Expected responses are
// queued at issue time and checked by an independent ack monitor.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2];
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [31:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
    logic        ack0 [2], ack1 [2], err [2];
    logic [31:0] rdata [2], mem_address [2], mem_data_input [2], mem_data_Out [2];
    logic        mem_MemRead [2], mem_MemWrite [2];

    logic [31:0] mem [2][64];
    logic [31:0] refmem [2][64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_i = '0;
    logic [31:0] pl_d [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          inst;
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: synchronous write, combinational read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pl_en) mem[k][pl_i] <= pl_d[k];
            else if (mem_MemWrite[k] && mem_address[k] < 32'd256)
                mem[k][mem_address[k][7:2]] <= mem_data_input[k];
        end
    end
    assign mem_data_Out[0] = mem[0][mem_address[0][7:2]];
    assign mem_data_Out[1] = mem[1][mem_address[1][7:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
        .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .err(err[0]), .rdata(rdata[0]),
        .mem_address(mem_address[0]), .mem_data_input(mem_data_input[0]),
        .mem_MemRead(mem_MemRead[0]), .mem_MemWrite(mem_MemWrite[0]),
        .mem_data_Out(mem_data_Out[0])
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256), .WAIT_STATES(2)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
        .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .err(err[1]), .rdata(rdata[1]),
        .mem_address(mem_address[1]), .mem_data_input(mem_data_input[1]),
        .mem_MemRead(mem_MemRead[1]), .mem_MemWrite(mem_MemWrite[1]),
        .mem_data_Out(mem_data_Out[1])
    );

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h", name, k, act, exp);
        end
    endfunction

    // Monitor: every ack is matched against the oldest expectation for that port.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_MemRead[k] || mem_MemWrite[k])
                check("ctrl_exclusive", k, {31'b0, mem_MemRead[k] & mem_MemWrite[k]}, 32'd0);
            if (ack0[k] || ack1[k]) begin
                int p;
                int idx;
                check("ack_onehot", k, {31'b0, ack0[k] & ack1[k]}, 32'd0);
                p = ack1[k] ? 1 : 0;
                idx = -1;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].inst == k && sbq[i].port == p) begin
                        idx = i;
                        break;
                    end
                end
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack inst%0d: got ack on port %0d expected none", k, p);
                end else begin
                    check("err", k, {31'b0, err[k]}, {31'b0, sbq[idx].err});
                    check("rdata", k, rdata[k], sbq[idx].rdata);
                    sbq.delete(idx);
                end
            end
        end
    end

    task automatic drive(input int k, input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0[k] = r; we0[k] = w; addr0[k] = a; wdata0[k] = d;
        end else begin
            req1[k] = r; we1[k] = w; addr1[k] = a; wdata1[k] = d;
        end
    endtask

    function automatic logic ack_of(int k, int p);
        return (p == 1) ? ack1[k] : ack0[k];
    endfunction

    // Reference model: errors return 0, writes return 0 and update refmem,
    // reads return refmem (or a caller-supplied value when ordering matters).
    task automatic issue(input int k, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit ovr, input logic [31:0] ovr_rd,
                         input bit drop, output int lat, output int nctl);
        exp_t e;
        int   start;
        e.inst  = k;
        e.port  = p;
        e.err   = (a[1:0] != 2'b00) || (a >= 32'd256);
        e.rdata = '0;
        if (!e.err) begin
            if (w) refmem[k][a[7:2]] = d;
            else e.rdata = ovr ? ovr_rd : refmem[k][a[7:2]];
        end
        sbq.push_back(e);
        @(negedge clk);
        drive(k, p, 1'b1, w, a, d);
        start = cyc;
        lat   = -1;
        nctl  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack_of(k, p)) begin
                lat = cyc - start;
                break;
            end
            if (mem_MemRead[k] || mem_MemWrite[k]) nctl++;
            // After grant: withdraw the request and scramble the fields.
            if (drop && i == 1) drive(k, p, 1'b0, ~w, $urandom, $urandom);
        end
        drive(k, p, 1'b0, 1'b0, '0, '0);
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout inst%0d port%0d: got no ack expected ack within 40 cycles", k, p);
        end
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_flags"}, k,
              {27'b0, ack0[k], ack1[k], err[k], mem_MemRead[k], mem_MemWrite[k]}, 32'd0);
        check({tag, "_rdata"}, k, rdata[k], 32'd0);
        check({tag, "_maddr"}, k, mem_address[k], 32'd0);
        check({tag, "_mdata"}, k, mem_data_input[k], 32'd0);
    endtask

    task automatic rand_port(input int k, input int p);
        int          lat, nc;
        logic [31:0] a;
        int          r;
        repeat (25) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = 32'(p * 128 + $urandom_range(0, 31) * 4);
            r = $urandom_range(0, 7);
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'(256 + $urandom_range(0, 1023));
            issue(k, p, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, '0, 1'b0, lat, nc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int          lat, nc, lat0, lat1, nc0, nc1, start;
        logic [31:0] v;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            drive(k, 0, 1'b0, 1'b0, '0, '0);
            drive(k, 1, 1'b0, 1'b0, '0, '0);
        end
        // Preload both memories (and the model) while reset is held.
        pl_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_i = 6'(i);
            for (int k = 0; k < 2; k++) begin
                v = $urandom;
                if (k == 0 && i == 0) v = 32'hA01100AB;
                if (k == 1 && i == 1) v = 32'h10101011;
                pl_d[k] = v;
                refmem[k][i] = v;
            end
        end
        @(negedge clk);
        pl_en = 1'b0;
        check_zero(0, "reset");
        check_zero(1, "reset");
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Single read, zero wait states.
        issue(0, 0, 1'b0, 32'h00, '0, 1'b0, '0, 1'b0, lat, nc);
        check("t1_latency", 0, lat, 2);
        check("t1_ctrl_cycles", 0, nc, 1);

        // Back to pointer 0, then contending write(p0)/read(p1) of the same word.
        @(negedge clk); reset[0] = 1'b1;
        @(negedge clk); reset[0] = 1'b0;
        fork
            issue(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, '0, 1'b0, lat0, nc0);
            issue(0, 1, 1'b0, 32'h10, '0, 1'b1, 32'hDEADBEEF, 1'b0, lat1, nc1);
        join
        check("t2_p0_latency", 0, lat0, 2);
        check("t2_p1_latency", 0, lat1, 5);
        // Port 0 served alone leaves the pointer on port 1.
        issue(0, 0, 1'b0, 32'h10, '0, 1'b0, '0, 1'b0, lat, nc);
        fork
            issue(0, 0, 1'b0, 32'h00, '0, 1'b0, '0, 1'b0, lat0, nc0);
            issue(0, 1, 1'b0, 32'h10, '0, 1'b0, '0, 1'b0, lat1, nc1);
        join
        check("t2b_p1_latency", 0, lat1, 2);
        check("t2b_p0_latency", 0, lat0, 5);

        // Misaligned and out-of-range accesses.
        issue(0, 1, 1'b0, 32'h06, '0, 1'b0, '0, 1'b0, lat, nc);
        check("t3_misalign_latency", 0, lat, 1);
        check("t3_misalign_ctrl", 0, nc, 0);
        issue(0, 1, 1'b0, 32'h100, '0, 1'b0, '0, 1'b0, lat, nc);
        check("t3_range_latency", 0, lat, 1);
        check("t3_range_ctrl", 0, nc, 0);

        // Two wait states.
        issue(1, 0, 1'b0, 32'h04, '0, 1'b0, '0, 1'b0, lat, nc);
        check("t4_latency", 1, lat, 4);
        check("t4_ctrl_cycles", 1, nc, 3);

        // Request withdrawn and fields changed after grant, then read back.
        issue(0, 0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, '0, 1'b1, lat, nc);
        check("t5_drop_latency", 0, lat, 2);
        issue(0, 1, 1'b0, 32'h20, '0, 1'b0, '0, 1'b0, lat, nc);

        // Reset during ACCESS; the held request is re-granted afterwards.
        begin
            exp_t e;
            e.inst = 1; e.port = 1; e.err = 1'b0; e.rdata = refmem[1][2];
            sbq.push_back(e);
        end
        @(negedge clk);
        drive(1, 1, 1'b1, 1'b0, 32'h08, '0);
        @(negedge clk);
        check("t6_in_access", 1, {31'b0, mem_MemRead[1]}, 32'd1);
        reset[1] = 1'b1;
        #1;
        check_zero(1, "t6_reset");
        @(negedge clk);
        @(negedge clk);
        reset[1] = 1'b0;
        start = cyc;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack1[1]) begin
                lat = cyc - start;
                break;
            end
        end
        drive(1, 1, 1'b0, 1'b0, '0, '0);
        check("t6_regrant_latency", 1, lat, 4);

        // Randomised traffic; each port owns half of the address space.
        fork
            rand_port(0, 0);
            rand_port(0, 1);
            rand_port(1, 0);
            rand_port(1, 1);
        join

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 0, sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the debug/DMA loader.
- Round-robin arbitration, one transaction in flight, req/ack handshake per port.
- Drives the memory's data_input, address, MemRead and MemWrite.
- Captures the memory's combinational data_Out into a registered response.

Parameters:
- ADDR_W, 32, width of byte address on requester and memory side
- DATA_W, 32, data word width
- MEM_BYTES, 256, size of valid byte-address space; addresses >= MEM_BYTES are errors
- WAIT_STATES, 0, extra cycles the memory controls are held per access (0..7)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1 each  transaction request, held until matching ack
- we0, we1  in  1 each  1 = write, 0 = read; valid while req high
- addr0, addr1  in  ADDR_W each  byte address, word aligned
- wdata0, wdata1  in  DATA_W each  write data
- ack0, ack1  out  1 each  one-cycle completion pulse
- err  out  1  valid with ack; 1 = misaligned or out-of-range access
- rdata  out  DATA_W  read data, valid with ack
- mem_address  out  ADDR_W  to memory address
- mem_data_input  out  DATA_W  to memory data_input
- mem_MemRead, mem_MemWrite  out  1 each  to memory controls
- mem_data_Out  in  DATA_W  from memory data_Out, combinational

Behaviour:
- Reset values:
  - FSM is IDLE and the priority pointer is 0.
  - ack0, ack1, err, mem_MemRead and mem_MemWrite are 0.
  - rdata, mem_address and mem_data_input are 0.
  - Wait counter is 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - With no req, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port named by the priority pointer.
  - On grant, latch port id, we, addr and wdata.
  - If addr[1:0] != 0 or addr >= MEM_BYTES, go to RESP with err pending. Otherwise go to ACCESS and load wait counter = WAIT_STATES.
- ACCESS:
  - mem_address and mem_data_input are driven from the latched values.
  - Exactly one of mem_MemRead or mem_MemWrite is high; they are never high together.
  - Counter decrements each cycle. When it reaches 0: for a read, capture mem_data_Out into rdata; then go to RESP.
- RESP:
  - ack of the granted port is high for exactly one cycle; err is valid.
  - rdata holds the captured read data, or 0 for writes and errors.
  - mem controls are 0.
  - Priority pointer is set to the non-granted port.
  - Next state is IDLE.
- Outside RESP, ack0, ack1 and err are 0. Outside ACCESS, memory controls are 0.
- Latency (req high in IDLE to ack) is WAIT_STATES+2 cycles for valid accesses and 1 cycle for errors. Peak throughput is one transaction per WAIT_STATES+3 cycles.
- Req dropped before ack: the transaction still completes and ack still pulses.
- Req held high through the ack cycle is treated as a new request in the following IDLE cycle.
- Only the latched inputs are used after grant. Changes to addr, we or wdata after grant are ignored.
- Reset asserted mid-transaction: immediate return to reset values. The transaction is lost, no ack is issued, and a partial write may have occurred.
- No address translation: the byte address is passed through unchanged.

Decomposition:
- Shared header dmem_ctrl_defs holds:
  - state encodings S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2
  - port ids
  - MEM_BYTES default
- One sub-module, rr_arb2:
  - Combinational inputs: req0, req1, pointer.
  - Output: grant id and grant valid.
  - Keeps the priority logic separately verifiable.

Test Plan:
- Memory preloaded with 0xA01100AB at address 0x00, WAIT_STATES=0. req0 read of 0x00 raised at cycle 0 -> mem_MemRead high at cycle 1; ack0=1, rdata=0xA01100AB, err=0 at cycle 2; ack1 never pulses.
- req0 write 0xDEADBEEF to 0x10 and req1 read of 0x10 raised in the same cycle -> port 0 acked first. Port 1 is then acked with rdata=0xDEADBEEF. A next simultaneous pair is granted to port 1 first.
- req1 read of addr 0x06 -> ack1 one cycle later with err=1, rdata=0, no memory control asserted. Repeat with addr 0x100 -> same result.
- WAIT_STATES=2, req0 read of 0x04 containing 0x10101011 -> mem_MemRead high for 3 consecutive cycles, ack0 at cycle 4 with rdata=0x10101011.
- reset pulsed during ACCESS of a req1 read -> all outputs 0 the same cycle, no ack1. After release with req1 still high, the transaction is re-granted and acked normally.
